// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA engine behind register FF46.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  localparam logic [15:0] ADDR_DMA = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int unsigned OAM_SIZE = 160;

  // Echo RAM (E0xx-FFxx) reads from WRAM 0x20 pages lower; the result never drops below C0.
  function automatic logic [7:0] echo_remap(input logic [7:0] hi, input logic en);
    return (en && hi >= 8'hE0) ? hi - 8'h20 : hi;
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the FF46 register decode / memory bus and the OAM DMA engine.
interface oam_dma_if;
  logic        reg_write;
  logic [7:0]  reg_d_wr;
  logic [7:0]  reg_d_rd;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_in;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;

  modport slave (
    input  reg_write, reg_d_wr, dma_d_in,
    output reg_d_rd, dma_active, dma_addr, oam_addr, oam_d_wr, oam_write
  );

  modport master (
    output reg_write, reg_d_wr, dma_d_in,
    input  reg_d_rd, dma_active, dma_addr, oam_addr, oam_d_wr, oam_write
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XX00..XX(LEN-1) into OAM one byte per M-cycle after a write
// of XX to FF46, with a one-M-cycle write stage trailing the bus read.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned XFER_LEN    = OAM_SIZE,
  parameter int unsigned START_DELAY = 1,
  parameter int unsigned ECHO_REMAP  = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ce,
  oam_dma_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(XFER_LEN);
  localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);
  localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(START_DELAY - 1);

  dma_state_t       state_q;
  logic [7:0]       src_q;
  logic [7:0]       reg_d_rd_q;
  logic [IDX_W-1:0] idx_q;
  logic [DLY_W-1:0] dly_q;
  logic             restart_q;
  logic [15:0]      dma_addr_q;
  logic [7:0]       wr_data_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_pending_q;

  logic [7:0]       src_eff;
  logic [IDX_W-1:0] idx_d;

  assign src_eff = echo_remap(src_q, ECHO_REMAP != 0);
  assign idx_d   = idx_q + 1'b1;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values
  // regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DMA_IDLE;
      src_q        <= 8'h00;
      reg_d_rd_q   <= 8'h00;
      idx_q        <= '0;
      dly_q        <= '0;
      restart_q    <= 1'b0;
      dma_addr_q   <= 16'h0000;
      wr_data_q    <= 8'h00;
      wr_idx_q     <= '0;
      wr_pending_q <= 1'b0;
    end else if (ce) begin
      if (bus.reg_write) reg_d_rd_q <= bus.reg_d_wr;

      // The byte read this M-cycle is written to OAM during the next one, even on restart.
      if (state_q == DMA_XFER) begin
        wr_data_q    <= bus.dma_d_in;
        wr_idx_q     <= idx_q;
        wr_pending_q <= 1'b1;
      end else begin
        wr_pending_q <= 1'b0;
      end

      case (state_q)
        DMA_IDLE: begin
          if (bus.reg_write) begin
            state_q   <= DMA_START;
            src_q     <= bus.reg_d_wr;
            idx_q     <= '0;
            dly_q     <= '0;
            restart_q <= 1'b0;
          end
        end
        DMA_START: begin
          if (bus.reg_write) begin
            src_q     <= bus.reg_d_wr;
            idx_q     <= '0;
            dly_q     <= '0;
            restart_q <= 1'b1;
          end else if (dly_q == LAST_DLY) begin
            state_q    <= DMA_XFER;
            dma_addr_q <= {src_eff, 8'(idx_q)};
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        DMA_XFER: begin
          // A write landing on the final read still restarts rather than finishing.
          if (bus.reg_write) begin
            state_q   <= DMA_START;
            src_q     <= bus.reg_d_wr;
            idx_q     <= '0;
            dly_q     <= '0;
            restart_q <= 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_q <= DMA_IDLE;
          end else begin
            idx_q      <= idx_d;
            dma_addr_q <= {src_eff, 8'(idx_d)};
          end
        end
        default: state_q <= DMA_IDLE;
      endcase
    end
  end

  assign bus.reg_d_rd   = reg_d_rd_q;
  assign bus.dma_active = (state_q == DMA_XFER) || ((state_q == DMA_START) && restart_q);
  assign bus.dma_addr   = dma_addr_q;
  assign bus.oam_write  = wr_pending_q;
  assign bus.oam_addr   = 8'(wr_idx_q);
  assign bus.oam_d_wr   = wr_data_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: per-M-cycle timing checks plus a scoreboard of OAM writes.
module tb_oam_dma;
  import oam_dma_pkg::*;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
  } oam_wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  oam_dma_if bus ();

  oam_dma dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  oam_wr_t exp_q[$];
  logic [7:0] oam_shadow [OAM_SIZE];

  // Source memory: byte = low address ^ (page - C1), so page C1 holds its own index.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'hC1);
  endfunction

  function automatic logic [7:0] remap(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  assign bus.dma_d_in = mem_byte(bus.dma_addr);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, bus.reg_d_rd, bus.dma_active, bus.dma_addr,
            bus.oam_addr, bus.oam_d_wr, bus.oam_write};
  endfunction

  // An OAM write commits only on a clock where ce is high.
  always @(negedge clk) begin
    if (!rst && ce && bus.oam_write) begin
      if (exp_q.size() == 0) begin
        check("oam_unexpected_write", 1, 0);
      end else begin
        oam_wr_t e;
        e = exp_q.pop_front();
        check("oam_addr", bus.oam_addr, e.idx);
        check("oam_data", bus.oam_d_wr, e.data);
        oam_shadow[bus.oam_addr] = bus.oam_d_wr;
      end
    end
  end

  task automatic push_expected(input logic [7:0] val, input int n);
    logic [7:0] se;
    se = remap(val);
    for (int i = 0; i < n; i++) begin
      oam_wr_t e;
      e.idx  = 8'(i);
      e.data = mem_byte({se, 8'(i)});
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an FF46 write; returns one time unit after the write edge (M-cycle 1).
  task automatic ff46_write(input logic [7:0] val, input int n_expected);
    push_expected(val, n_expected);
    bus.reg_write = 1'b1;
    bus.reg_d_wr  = val;
    tick();
    bus.reg_write = 1'b0;
  endtask

  // Full transfer with per-M-cycle expectations; optionally stall ce for 3 clocks at one M-cycle.
  task automatic run_xfer(input logic [7:0] val, input bit restarted,
                          input logic [15:0] prev_addr, input int stall_at);
    logic [7:0]  se;
    logic [15:0] exp_addr;
    logic        exp_act;
    logic        exp_wr;
    int          k;
    se = remap(val);
    ff46_write(val, OAM_SIZE);
    check("readback", bus.reg_d_rd, val);
    for (int m = 1; m <= OAM_SIZE + 3; m++) begin
      k        = (m - 2 > OAM_SIZE - 1) ? OAM_SIZE - 1 : m - 2;
      exp_addr = (m < 2) ? prev_addr : {se, k[7:0]};
      exp_act  = (m >= 2 && m <= OAM_SIZE + 1) || (m == 1 && restarted);
      exp_wr   = (m >= 3 && m <= OAM_SIZE + 2) || (m == 1 && restarted);
      check("dma_active", bus.dma_active, exp_act);
      check("dma_addr", bus.dma_addr, exp_addr);
      check("oam_write", bus.oam_write, exp_wr);
      if (m == stall_at) begin
        ce = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_active", bus.dma_active, exp_act);
          check("stall_addr", bus.dma_addr, exp_addr);
          check("stall_oam", {bus.oam_write, bus.oam_addr}, {exp_wr, 8'(m - 3)});
        end
        ce = 1'b1;
      end
      tick();
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_write = 1'b0;
    bus.reg_d_wr  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 500; i++) begin
      tick();
      check("idle_outs", all_outs(), 0);
    end

    // 2: plain transfer from C1xx
    run_xfer(8'hC1, 1'b0, 16'h0000, 0);
    check("oam_c1_last", oam_shadow[159], 8'd159);

    // 3: echo page E5 reads from C5
    run_xfer(8'hE5, 1'b0, 16'hC19F, 0);
    check("readback_e5", bus.reg_d_rd, 8'hE5);

    // 4: restart from page 80 to C0 while byte 50 is being read
    ff46_write(8'h80, 51);
    for (int i = 0; i < 300 && bus.dma_addr !== 16'h8032; i++) tick();
    check("wait_idx50", bus.dma_addr, 16'h8032);
    run_xfer(8'hC0, 1'b1, 16'h8032, 0);
    check("oam_c0_0", oam_shadow[0], mem_byte(16'hC000));
    check("oam_c0_50", oam_shadow[50], mem_byte(16'hC032));
    check("oam_c0_159", oam_shadow[159], mem_byte(16'hC09F));

    // 5: asynchronous reset while byte 77 is read
    ff46_write(8'hC2, OAM_SIZE);
    for (int i = 0; i < 300 && bus.dma_addr !== 16'hC24D; i++) tick();
    check("wait_idx77", bus.dma_addr, 16'hC24D);
    #1 rst = 1'b1;
    #1 check("async_rst_outs", all_outs(), 0);
    check("rst_writes_left", exp_q.size(), 84);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_rst_outs", all_outs(), 0);
    end

    // 6: ce stall mid-transfer
    run_xfer(8'hC3, 1'b0, 16'h0000, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
